// File: rtl/packed_hex_hold_display.sv
// rtl/packed_hex_hold_display.sv - holds a packed hex word on a 4-digit 7-seg display, then pulses done
//
// Captures a 16-bit packed hex word, keeps it frozen on a multiplexed
// four-digit seven-segment display for HOLD_CYCLES clocks, then pulses
// done for one cycle so the producer can advance to its next vector.
//
// Ports:
//   clk       - system clock, rising edge
//   btnU      - synchronous active-high reset
//   packedHex - word to display; nibble 3 leftmost, nibble 0 rightmost
//   seg[0:6]  - segment cathodes a..g, active-low, registered
//   an[3:0]   - digit anodes, active-low one-hot, an[0] rightmost, registered
//   done      - one-cycle pulse at the end of each hold window, registered
module packed_hex_hold_display #(
    parameter int CLK_HZ      = 100000000,
    parameter int HOLD_MS     = 500,
    parameter int SCAN_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        btnU,
    input  logic [15:0] packedHex,
    output logic [0:6]  seg,
    output logic [3:0]  an,
    output logic        done
);

    // 64-bit product so the default 100 MHz x 500 ms does not overflow.
    localparam longint unsigned HOLD_CYCLES =
        (longint'(CLK_HZ) * longint'(HOLD_MS)) / 1000;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = $clog2(SCAN_CYCLES);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t          state_q;
    logic [15:0]     disp_q;
    logic [HW-1:0]   hold_cnt_q;
    logic [SW-1:0]   scan_cnt_q;
    logic [1:0]      digit_q;
    logic            done_q;
    logic [3:0]      an_q;
    logic [0:6]      seg_q;

    // Active-low abcdefg pattern; bit 6 is segment a.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'b0000001;
            4'h1:    hex7 = 7'b1001111;
            4'h2:    hex7 = 7'b0010010;
            4'h3:    hex7 = 7'b0000110;
            4'h4:    hex7 = 7'b1001100;
            4'h5:    hex7 = 7'b0100100;
            4'h6:    hex7 = 7'b0100000;
            4'h7:    hex7 = 7'b0001111;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0000100;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b1100000;
            4'hC:    hex7 = 7'b0110001;
            4'hD:    hex7 = 7'b1000010;
            4'hE:    hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (btnU) begin
            state_q    <= ST_LOAD;
            disp_q     <= '0;
            hold_cnt_q <= '0;
            scan_cnt_q <= '0;
            digit_q    <= '0;
            done_q     <= 1'b0;
            an_q       <= 4'b1111;
            seg_q      <= 7'b1111111;
        end else begin
            // Control FSM: done_q is set on the HOLD->DONE edge so it is
            // high exactly while the FSM sits in DONE.
            done_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    disp_q     <= packedHex;
                    hold_cnt_q <= HW'(HOLD_CYCLES - 1);
                    state_q    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_LOAD;
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase

            // Free-running digit scan, independent of the FSM.
            if (scan_cnt_q == SW'(SCAN_CYCLES - 1)) begin
                scan_cnt_q <= '0;
                digit_q    <= digit_q + 2'd1;
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end

            // Blank all anodes in the first cycle of each slot so the
            // previous digit's segments never ghost onto the new digit.
            if (scan_cnt_q == '0) begin
                an_q <= 4'b1111;
            end else begin
                an_q <= ~(4'b0001 << digit_q);
            end
            seg_q <= hex7(disp_q[{digit_q, 2'b00} +: 4]);
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign done = done_q;

endmodule

// File: tb/tb_packed_hex_hold_display.sv
// tb/tb_packed_hex_hold_display.sv - directed self-checking bench for packed_hex_hold_display
module tb_packed_hex_hold_display;

    logic        clk;
    logic        btnU;
    logic [15:0] packedHex;
    logic [0:6]  seg;
    logic [3:0]  an;
    logic        done;

    int tests_run;
    int tests_failed;
    int k;

    logic [6:0] seg_tbl [16];

    packed_hex_hold_display #(
        .CLK_HZ     (1000),
        .HOLD_MS    (10),
        .SCAN_CYCLES(4)
    ) dut (
        .clk      (clk),
        .btnU     (btnU),
        .packedHex(packedHex),
        .seg      (seg),
        .an       (an),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle k counts from the LOAD cycle (k = 0) following reset release.
    // Outputs in cycle k reflect scan state of cycle k-1; scan_cnt = k % 4.
    function automatic logic [3:0] exp_an(input int kk);
        int s;
        int d;
        s = (kk - 1) % 4;
        d = ((kk - 1) / 4) % 4;
        if (s == 0) return 4'b1111;
        return ~(4'b0001 << d);
    endfunction

    function automatic int exp_digit(input int kk);
        return ((kk - 1) / 4) % 4;
    endfunction

    task automatic do_reset();
        btnU = 1'b1;
        @(posedge clk);
        @(negedge clk);
        btnU = 1'b0;
        k = 0;
    endtask

    task automatic step();
        @(negedge clk);
        k = k + 1;
    endtask

    task automatic test_reset();
        btnU = 1'b1;
        packedHex = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || an !== 4'b1111 || seg !== 7'b1111111) begin
            tests_failed++;
            $display("FAIL reset_state: done=%b an=%b seg=%b, want 0 1111 1111111", done, an, seg);
        end
    endtask

    task automatic test_done_timing();
        logic want;
        packedHex = 16'h1234;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            step();
            want = (k >= 11) && ((k - 11) % 12 == 0);
            tests_run++;
            if (done !== want) begin
                tests_failed++;
                $display("FAIL done_timing k=%0d: done=%b want %b", k, done, want);
            end
        end
    endtask

    task automatic test_scan();
        logic [6:0] dig_seg [4];
        dig_seg[0] = 7'b0000001;
        dig_seg[1] = 7'b0111000;
        dig_seg[2] = 7'b0000000;
        dig_seg[3] = 7'b0001000;
        packedHex = 16'hA8F0;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step();
            tests_run++;
            if (an !== exp_an(k)) begin
                tests_failed++;
                $display("FAIL scan_an k=%0d: an=%b want %b", k, an, exp_an(k));
            end
            if (k >= 2 && exp_an(k) != 4'b1111) begin
                tests_run++;
                if (seg !== dig_seg[exp_digit(k)]) begin
                    tests_failed++;
                    $display("FAIL scan_seg k=%0d: seg=%b want %b", k, seg, dig_seg[exp_digit(k)]);
                end
            end
        end
    endtask

    // Producer advances the word on done; noise is driven mid-HOLD and
    // must never reach the display.
    task automatic test_producer();
        int j;
        logic [6:0] want;
        logic [15:0] word;
        word = 16'h0000;
        packedHex = word;
        do_reset();
        for (int i = 1; i <= 37; i++) begin
            step();
            if (done === 1'b1) begin
                word = word + 16'h0001;
                packedHex = word;
            end else if (k % 12 == 2) begin
                packedHex = 16'hFFFF;
            end else if (k % 12 == 10) begin
                packedHex = word;
            end
            if (k >= 2 && exp_an(k) != 4'b1111) begin
                j = (k - 2) / 12;
                want = (exp_digit(k) == 0) ? seg_tbl[j] : seg_tbl[0];
                tests_run++;
                if (seg !== want) begin
                    tests_failed++;
                    $display("FAIL producer_seg k=%0d: seg=%b want %b", k, seg, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        packedHex = 16'h1234;
        do_reset();
        for (int i = 1; i <= 6; i++) step();
        btnU = 1'b1;
        @(negedge clk);
        tests_run++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_hold_reset: an=%b seg=%b done=%b, want 1111 1111111 0", an, seg, done);
        end
        btnU = 1'b0;
        k = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            tests_run++;
            if (done !== (k == 11)) begin
                tests_failed++;
                $display("FAIL mid_hold_done k=%0d: done=%b want %b", k, done, (k == 11));
            end
        end
    endtask

    task automatic test_reset_hold();
        btnU = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0 || an !== 4'b1111) begin
                tests_failed++;
                $display("FAIL reset_hold cyc=%0d: done=%b an=%b, want 0 1111", i, done, an);
            end
        end
        btnU = 1'b0;
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 16; v++) begin
            packedHex = 16'(v);
            do_reset();
            step();
            step();
            tests_run++;
            if (an !== 4'b1110 || seg !== seg_tbl[v]) begin
                tests_failed++;
                $display("FAIL sweep nib=%h: an=%b seg=%b, want 1110 %b", v[3:0], an, seg, seg_tbl[v]);
            end
        end
    endtask

    initial begin
        seg_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        tests_run = 0;
        tests_failed = 0;
        k = 0;
        btnU = 1'b1;
        packedHex = 16'h0000;

        test_reset();
        test_done_timing();
        test_scan();
        test_producer();
        test_reset_mid_hold();
        test_reset_hold();
        test_sweep();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
